// File: rtl/fetch_prefetch.sv
// Instruction fetch unit: pipelined Wishbone read master feeding a prefetch FIFO toward DECODE.
// Outstanding requests plus queued entries never exceed FIFO_DEPTH, so the FIFO cannot overflow.
module fetch_prefetch #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    input  logic                  wb_stall_i,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    input  logic                  wb_ack_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  dc_valid_o,
    input  logic                  dc_ready_i,
    output logic [ADDR_WIDTH-1:0] dc_addr_o,
    output logic [DATA_WIDTH-1:0] dc_inst_o,
    input  logic                  dc_valid_i,
    input  logic [ADDR_WIDTH-1:0] dc_pc_i
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ABORT = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] inst;
    } entry_t;

    state_e                state_q, state_d;
    logic                  stb_q, stb_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] resp_q, resp_d;
    logic [CNT_W-1:0]      outst_q, outst_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  dc_valid_q, dc_valid_d;
    entry_t                head_q, head_d;
    entry_t                mem_q [FIFO_DEPTH];

    logic                  run;
    logic                  accept;
    logic                  push;
    logic                  pop;
    entry_t                push_entry;
    logic [CNT_W-1:0]      remain;
    logic [SUM_W-1:0]      used_d;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a redirect always passes through one ABORT cycle with the bus idle
    always_comb begin
        state_d = state_q;
        if (dc_valid_i) begin
            state_d = S_ABORT;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_ABORT: state_d = S_RUN;
                S_RUN:   state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs and per-cycle handshake events; a redirect masks strobe and acks immediately
    always_comb begin
        run        = (state_q == S_RUN);
        wb_stb_o   = stb_q & ~dc_valid_i;
        wb_cyc_o   = wb_stb_o | (outst_q != '0);
        wb_addr_o  = addr_q;
        accept     = run & wb_stb_o & ~wb_stall_i;
        push       = run & wb_cyc_o & wb_ack_i & (outst_q != '0) & ~dc_valid_i;
        pop        = dc_valid_q & dc_ready_i;
        push_entry = {resp_q, wb_data_i};
        dc_valid_o = dc_valid_q;
        dc_addr_o  = head_q.addr;
        dc_inst_o  = head_q.inst;
    end

    // Datapath next values: credit accounting, FIFO pointers and the registered head
    always_comb begin
        stb_d      = stb_q;
        addr_d     = addr_q;
        pc_d       = pc_q;
        resp_d     = resp_q;
        outst_d    = outst_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        dc_valid_d = dc_valid_q;
        head_d     = head_q;
        remain     = count_q - CNT_W'(pop);
        used_d     = '0;

        if (dc_valid_i) begin
            stb_d      = 1'b0;
            pc_d       = dc_pc_i;
            resp_d     = dc_pc_i;
            outst_d    = '0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            dc_valid_d = 1'b0;
        end else begin
            outst_d = outst_q + CNT_W'(accept) - CNT_W'(push);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                resp_d   = resp_q + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (remain != '0) begin
                head_d = mem_q[rd_ptr_d];
            end else if (push) begin
                head_d = push_entry;
            end
            dc_valid_d = (count_d != '0);

            used_d = SUM_W'(count_d) + SUM_W'(outst_d);
            if (state_d == S_RUN) begin
                if (run && stb_q && wb_stall_i) begin
                    stb_d = 1'b1;
                end else if (used_d < SUM_W'(FIFO_DEPTH)) begin
                    stb_d  = 1'b1;
                    addr_d = pc_q;
                    pc_d   = pc_q + ADDR_WIDTH'(1);
                end else begin
                    stb_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stb_q      <= 1'b0;
            addr_q     <= '0;
            pc_q       <= '0;
            resp_q     <= '0;
            outst_q    <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dc_valid_q <= 1'b0;
            head_q     <= '0;
        end else begin
            stb_q      <= stb_d;
            addr_q     <= addr_d;
            pc_q       <= pc_d;
            resp_q     <= resp_d;
            outst_q    <= outst_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dc_valid_q <= dc_valid_d;
            head_q     <= head_d;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule
